// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory port bundle for load_store_unit
//
// Ports (grouped signals):
//   req_valid/req_ready      request handshake from the execute stage
//   req_write/req_size/req_unsigned/req_addr/req_wdata   request fields
//   resp_valid/resp_rdata/resp_err                       completion pulse and result
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata      big-endian word-wide data memory
// Modports: slave = the load/store unit's view, master = requester plus memory view.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store initiator for a big-endian word memory
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    load_store_unit_if.slave: request handshake, response pulse, data-memory strobes
// Sub-word stores are read-modify-write because the memory has no byte enables.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state, state_nxt;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        req_err;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] store_merge;

    assign accept         = bus.req_valid && (state == S_IDLE);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Range check is against the last full word so that any access touching
    // bytes beyond the memory is rejected regardless of size.
    always_comb begin
        req_err = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
               || (bus.req_addr > LAST_WORD);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 32'h0;
        bus.mem_wdata  = 32'h0;
        bus.resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err)                                   state_nxt = S_DONE;
                    else if (bus.req_write && bus.req_size == 2'b10) state_nxt = S_WRITE;
                    else                                           state_nxt = S_READ;
                end
            end
            S_READ: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = {addr_q[31:2], 2'b00};
                state_nxt    = S_WAIT;
            end
            S_WAIT: state_nxt = wr_q ? S_WRITE : S_DONE;
            S_WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {addr_q[31:2], 2'b00};
                bus.mem_wdata = wdata_q;
                state_nxt     = S_DONE;
            end
            S_DONE: begin
                bus.resp_valid = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_byte = bus.mem_rdata[31:24];
            2'd1:    lane_byte = bus.mem_rdata[23:16];
            2'd2:    lane_byte = bus.mem_rdata[15:8];
            default: lane_byte = bus.mem_rdata[7:0];
        endcase
        lane_half = addr_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{~uns_q & lane_half[15]}}, lane_half};
            default: load_ext = bus.mem_rdata;
        endcase

        store_merge = bus.mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    store_merge[31:24] = wdata_q[7:0];
                2'd1:    store_merge[23:16] = wdata_q[7:0];
                2'd2:    store_merge[15:8]  = wdata_q[7:0];
                default: store_merge[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            store_merge[15:0] = wdata_q[15:0];
        end else begin
            store_merge[31:16] = wdata_q[15:0];
        end
    end

    // Response registers change only on entry to DONE so they hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= bus.req_write;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                if (req_err) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
            if (state == S_WAIT) begin
                if (wr_q) begin
                    wdata_q <= store_merge;
                end else begin
                    rdata_q <= load_ext;
                    err_q   <= 1'b0;
                end
            end
            if (state == S_WRITE) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if ifc();

    load_store_unit #(.MEM_BYTES(16384)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural data memory: registered read, full-word write.
    logic [31:0] mem [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_idx = 12'h0;
    logic [31:0] poke_val = 32'h0;
    int          wr_count = 0;

    always @(posedge clk) begin
        if (ifc.mem_read)  ifc.mem_rdata <= mem[ifc.mem_addr[13:2]];
        if (ifc.mem_write) begin
            mem[ifc.mem_addr[13:2]] <= ifc.mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (poke_en) mem[poke_idx] <= poke_val;
    end

    // Reference model: per-request timeline and expected values from the access rules.
    logic [31:0] ref_mem [0:4095];
    bit          started = 0, rst_prev = 0, active = 0, pend = 0;
    int          k = 0, lat = 0, read_k = 0, write_k = 0;
    logic [31:0] exp_rdata = 0, exp_wword = 0, exp_addr = 0, last_rdata = 0;
    bit          exp_err = 0, last_err = 0;
    logic        p_write = 0, p_uns = 0;
    logic [1:0]  p_size = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;

    task model_accept();
        int          o;
        logic [31:0] w, v, mask, ins;
        o = int'(p_addr[1:0]);
        w = ref_mem[p_addr[13:2]];
        exp_err = (p_size == 2'd3) || (p_size == 2'd1 && p_addr[0])
               || (p_size == 2'd2 && p_addr[1:0] != 2'd0) || (p_addr > 32'd16380);
        exp_rdata = 0; exp_wword = 0; read_k = 0; write_k = 0;
        exp_addr  = {p_addr[31:2], 2'b00};
        if (exp_err) begin
            lat = 1;
        end else if (!p_write) begin
            lat = 3; read_k = 1;
            if (p_size == 2'd0) begin
                v = (w >> (8 * (3 - o))) & 32'hFF;
                if (!p_uns && v[7]) v = v | 32'hFFFFFF00;
            end else if (p_size == 2'd1) begin
                v = (w >> (8 * (2 - o))) & 32'hFFFF;
                if (!p_uns && v[15]) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            exp_rdata = v;
        end else if (p_size == 2'd2) begin
            lat = 2; write_k = 1;
            exp_wword = p_wdata;
        end else begin
            lat = 4; read_k = 1; write_k = 3;
            if (p_size == 2'd0) begin
                mask = 32'hFF << (8 * (3 - o));
                ins  = (p_wdata & 32'hFF) << (8 * (3 - o));
            end else begin
                mask = 32'hFFFF << (8 * (2 - o));
                ins  = (p_wdata & 32'hFFFF) << (8 * (2 - o));
            end
            exp_wword = (w & ~mask) | ins;
        end
    endtask

    always @(negedge clk) begin
        if (poke_en) ref_mem[poke_idx] = poke_val;
        if (rst_prev) begin
            started = 1; active = 0; pend = 0;
            last_rdata = 0; last_err = 0;
            check("reset mem_addr", ifc.mem_addr, 32'h0);
            check("reset mem_wdata", ifc.mem_wdata, 32'h0);
        end else if (started) begin
            if (active) begin
                k++;
                if (k > lat) active = 0;
            end
            if (pend) begin
                model_accept();
                active = 1;
                k = 1;
            end
        end
        if (started) begin
            check("req_ready", {31'h0, ifc.req_ready}, {31'h0, !active});
            check("mem_read", {31'h0, ifc.mem_read}, {31'h0, active && k == read_k});
            check("mem_write", {31'h0, ifc.mem_write}, {31'h0, active && k == write_k});
            check("resp_valid", {31'h0, ifc.resp_valid}, {31'h0, active && k == lat});
            if (active && (k == read_k || k == write_k))
                check("mem_addr", ifc.mem_addr, exp_addr);
            if (active && k == write_k) begin
                check("mem_wdata", ifc.mem_wdata, exp_wword);
                ref_mem[exp_addr[13:2]] = exp_wword;
            end
            if (active && k == lat) begin
                last_rdata = exp_rdata;
                last_err   = exp_err;
            end
            check("resp_rdata", ifc.resp_rdata, last_rdata);
            check("resp_err", {31'h0, ifc.resp_err}, {31'h0, last_err});
        end
        rst_prev = reset;
        pend     = !reset && ifc.req_valid && ifc.req_ready;
        p_write  = ifc.req_write;
        p_size   = ifc.req_size;
        p_uns    = ifc.req_unsigned;
        p_addr   = ifc.req_addr;
        p_wdata  = ifc.req_wdata;
    end

    // Driver tasks; all start and end at posedge+1.
    task automatic poke(input logic [11:0] idx, input logic [31:0] val);
        poke_idx = idx; poke_val = val; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic do_req(input string name, input bit w, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                          input bit exp_e, input int exp_lat, input bit hold, output int waited);
        bit got;
        ifc.req_write = w; ifc.req_size = sz; ifc.req_unsigned = uns;
        ifc.req_addr = a; ifc.req_wdata = wd; ifc.req_valid = 1'b1;
        @(negedge clk);
        waited = 0;
        while (!ifc.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, " accepted"}, {31'h0, ifc.req_ready}, 32'h1);
        @(posedge clk); #1;
        if (!hold) ifc.req_valid = 1'b0;
        got = 0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (ifc.resp_valid) begin
                got = 1;
                check({name, " latency"}, i, exp_lat);
                check({name, " rdata"}, ifc.resp_rdata, exp_rd);
                check({name, " err"}, {31'h0, ifc.resp_err}, {31'h0, exp_e});
            end
        end
        check({name, " responded"}, {31'h0, got}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    int wt;
    initial begin
        reset = 1'b1;
        ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_size = 2'b00;
        ifc.req_unsigned = 1'b0; ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        poke(12'h040, 32'h812233F4);
        poke(12'hFFF, 32'hCAFE0123);
        reset = 1'b0;
        @(negedge clk);
        check("reset req_ready", {31'h0, ifc.req_ready}, 32'h1);
        check("reset resp_rdata", ifc.resp_rdata, 32'h0);
        @(posedge clk); #1;

        do_req("lb 0x100",  0, 2'd0, 0, 32'h100, 0, 32'hFFFFFF81, 0, 3, 0, wt);
        do_req("lbu 0x103", 0, 2'd0, 1, 32'h103, 0, 32'h000000F4, 0, 3, 0, wt);
        do_req("lh 0x100",  0, 2'd1, 0, 32'h100, 0, 32'hFFFF8122, 0, 3, 0, wt);
        do_req("lhu 0x102", 0, 2'd1, 1, 32'h102, 0, 32'h000033F4, 0, 3, 0, wt);
        do_req("lw 0x100",  0, 2'd2, 1, 32'h100, 0, 32'h812233F4, 0, 3, 0, wt);

        // sb abandoned by a reset during WAIT
        ifc.req_write = 1; ifc.req_size = 2'd0; ifc.req_unsigned = 0;
        ifc.req_addr = 32'h101; ifc.req_wdata = 32'h123456AA; ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", {31'h0, ifc.req_ready}, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("reset no write", wr_count, 0);
        check("reset word kept", mem[12'h040], 32'h812233F4);

        do_req("sb 0x101", 1, 2'd0, 0, 32'h101, 32'h123456AA, 32'h0, 0, 4, 0, wt);
        check("sb word", mem[12'h040], 32'h81AA33F4);
        poke(12'h040, 32'h812233F4);
        do_req("sh 0x102", 1, 2'd1, 0, 32'h102, 32'h0000BEEF, 32'h0, 0, 4, 0, wt);
        check("sh word", mem[12'h040], 32'h8122BEEF);
        do_req("sw 0x104", 1, 2'd2, 0, 32'h104, 32'hDEADBEEF, 32'h0, 0, 2, 0, wt);
        check("sw word", mem[12'h041], 32'hDEADBEEF);

        do_req("lw 0x102 err",   0, 2'd2, 0, 32'h102,  0, 32'h0, 1, 1, 0, wt);
        do_req("lh 0x101 err",   0, 2'd1, 0, 32'h101,  0, 32'h0, 1, 1, 0, wt);
        do_req("size11 err",     0, 2'd3, 0, 32'h100,  0, 32'h0, 1, 1, 0, wt);
        do_req("lw 0x3FFD err",  0, 2'd2, 0, 32'h3FFD, 0, 32'h0, 1, 1, 0, wt);
        do_req("sb 0x3FFD err",  1, 2'd0, 0, 32'h3FFD, 32'h55, 32'h0, 1, 1, 0, wt);
        do_req("sw 0x4000 err",  1, 2'd2, 0, 32'h4000, 32'h1, 32'h0, 1, 1, 0, wt);
        do_req("lw 0x3FFC",      0, 2'd2, 0, 32'h3FFC, 0, 32'hCAFE0123, 0, 3, 0, wt);

        poke(12'h040, 32'h812233F4);
        do_req("b2b lb",  0, 2'd0, 0, 32'h100, 0, 32'hFFFFFF81, 0, 3, 1, wt);
        do_req("b2b lbu", 0, 2'd0, 1, 32'h100, 0, 32'h00000081, 0, 3, 0, wt);
        check("b2b accept wait", wt, 0);

        repeat (3) @(posedge clk);
        #1;
        check("total writes", wr_count, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
